// File: rtl/swa_pkg.sv
// Shared types and helpers for the byte-serial wide adder sequencer.
package swa_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } swa_state_t;

  function automatic int unsigned nbytes(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/serial_wide_adder_ctrl.sv
// Feeds two WIDTH-bit operands to an external 8-bit adder one byte at a time, LSB first.
// Optional signed-overflow output enabled by defining SWA_OVERFLOW_EN.
module serial_wide_adder_ctrl
  import swa_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
`ifdef SWA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NBYTES = nbytes(WIDTH);
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  swa_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic             capture;

  // With a combinational adder the sum is taken in ISSUE; otherwise one cycle later in WAIT.
  always_comb begin
    capture = (ADD_LAT == 0) ? (state == ISSUE) : (state == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout_out <= 1'b0;
`ifdef SWA_OVERFLOW_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin_in;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ADD_LAT != 0) state <= WAIT;
        end
        WAIT:    ;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (capture) begin
        result[BYTE_W*idx +: BYTE_W] <= add_sum;
        carry <= add_cout;
        if (idx == LAST_IDX) begin
          cout_out <= add_cout;
`ifdef SWA_OVERFLOW_EN
          ovf      <= add_a[7] ^ add_b[7] ^ add_sum[7] ^ add_cout;
`endif
          state    <= DONE;
        end else begin
          idx   <= idx + 1'b1;
          state <= ISSUE;
        end
      end
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == ISSUE || state == WAIT) begin
      add_a   = a_reg[BYTE_W*idx +: BYTE_W];
      add_b   = b_reg[BYTE_W*idx +: BYTE_W];
      add_cin = carry;
    end
  end

  always_comb begin
    busy = (state == ISSUE) || (state == WAIT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Bench for serial_wide_adder_ctrl (WIDTH=32, ADD_LAT=1) with a registered 8-bit adder model.
module tb_serial_wide_adder_ctrl;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin_in = 1'b0;
  logic             busy, done, cout_out;
  logic [WIDTH-1:0] result;
  logic [7:0]       add_a, add_b, add_sum;
  logic             add_cin, add_cout;
`ifdef SWA_OVERFLOW_EN
  logic             ovf;
`endif

  int compared   = 0;
  int mismatched = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // 8-bit adder with one cycle of latency
  always_ff @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  serial_wide_adder_ctrl #(.WIDTH(WIDTH), .ADD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .busy(busy), .done(done), .result(result), .cout_out(cout_out),
`ifdef SWA_OVERFLOW_EN
    .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    exp_t e;
    e.sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", {31'd0, cout_out, result}, {31'd0, e.sum});
`ifdef SWA_OVERFLOW_EN
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
      end
    end
  end

  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input bit push);
    @(negedge clk);
    op_a   = a;
    op_b   = b;
    cin_in = c;
    start  = 1'b1;
    if (push) sb.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the negedge count after the start cycle at which done was seen (0 on timeout)
  task automatic wait_done(input int already, output int lat);
    lat = 0;
    if (done === 1'b1) begin
      lat = already;
      return;
    end
    for (int n = already + 1; n <= 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        return;
      end
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    repeat (3) @(negedge clk);
    check("rst_busy",   {63'd0, busy},     64'd0);
    check("rst_done",   {63'd0, done},     64'd0);
    check("rst_result", {32'd0, result},   64'd0);
    check("rst_cout",   {63'd0, cout_out}, 64'd0);
    check("rst_add",    {47'd0, add_a, add_b, add_cin}, 64'd0);
    rst_n = 1'b1;

    // Carry ripple, latency and busy
    drive_start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(1, lat);
    check("latency", 64'(lat), 64'd9);
    check("ripple_result", {32'd0, result}, 64'h0);
    check("ripple_cout", {63'd0, cout_out}, 64'd1);
    check("busy_in_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("add_a_idle", {56'd0, add_a}, 64'd0);

    // Plain add, started the cycle after done of the previous op is covered by the random run
    drive_start(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    wait_done(1, lat);
    check("plain_result", {32'd0, result}, 64'h2345_678A);
    check("plain_cout", {63'd0, cout_out}, 64'd0);

    // Signed overflow cases
    drive_start(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(1, lat);
    check("ovf_result", {32'd0, result}, 64'h8000_0000);
    drive_start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(1, lat);
    check("noovf_cout", {63'd0, cout_out}, 64'd1);

    // Start while busy is ignored
    drive_start(32'h0000_00F0, 32'h0000_0010, 1'b0, 1'b1);
    @(negedge clk);
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h1234_4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat);
    check("busy_start_latency", 64'(lat), 64'd9);
    check("busy_start_result", {32'd0, result}, 64'h0000_0100);
    repeat (12) @(negedge clk);

    // Reset in the middle of an operation: nothing pushed, so any done is flagged
    drive_start(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   {63'd0, busy},     64'd0);
    check("midrst_done",   {63'd0, done},     64'd0);
    check("midrst_result", {32'd0, result},   64'd0);
    check("midrst_cout",   {63'd0, cout_out}, 64'd0);
    check("midrst_add",    {47'd0, add_a, add_b, add_cin}, 64'd0);
`ifdef SWA_OVERFLOW_EN
    check("midrst_ovf",    {63'd0, ovf},      64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    drive_start(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b1);
    wait_done(1, lat);
    check("post_rst_latency", 64'(lat), 64'd9);

    // Back-to-back random operations, each started the cycle after done
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      drive_start(ra, rb, rc, 1'b1);
      wait_done(1, lat);
    end

    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
